// File: rtl/micro_sequencer.sv
// Microprogrammed sequencer: writable control store, BOOT/RUN/HALT FSM, micro-call stack.
// Latency: one word per cycle; upc and cw load together on the edge, ctrl is cw's upper field.
// Backpressure: ext_stall freezes RUN; a DISPATCH word waits for instr_valid (instr_ready is combinational).
// Ports: eclk/reset (sync, active-high); cs_we/cs_waddr/cs_wdata load the store in any state;
//   instr/instr_valid/instr_ready form the dispatch handshake; flags feed BRANCH and NOP-WAIT;
//   resume restarts from HALT; ctrl/ctrl_valid drive the datapath; upc, ir, halted, err are status.
module micro_sequencer #(
  parameter int AW          = 4,
  parameter int CW          = 29,
  parameter int DW          = 8,
  parameter int OPC_LSB     = 2,
  parameter int STACK_DEPTH = 4
) (
  input  logic             eclk,
  input  logic             reset,
  input  logic             cs_we,
  input  logic [AW-1:0]    cs_waddr,
  input  logic [CW-1:0]    cs_wdata,
  input  logic [DW-1:0]    instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       flags,
  input  logic             ext_stall,
  input  logic             resume,
  output logic [CW-AW-6:0] ctrl,
  output logic             ctrl_valid,
  output logic [AW-1:0]    upc,
  output logic [DW-1:0]    ir,
  output logic             halted,
  output logic [1:0]       err
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] M_SEQ  = 3'd0;
  localparam logic [2:0] M_JMP  = 3'd1;
  localparam logic [2:0] M_DISP = 3'd2;
  localparam logic [2:0] M_BR   = 3'd3;
  localparam logic [2:0] M_CALL = 3'd4;
  localparam logic [2:0] M_RET  = 3'd5;
  localparam logic [2:0] M_WAIT = 3'd6;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cs [2**AW];
  logic [CW-1:0]   cw;
  logic [AW-1:0]   nxt;
  logic [SPW-1:0]  sp;
  logic [SPW-1:0]  sp_dec;
  logic [AW-1:0]   stk [STACK_DEPTH];
  logic [SIW-1:0]  push_idx, pop_idx;

  logic [2:0]      mode;
  logic [1:0]      csel;
  logic [AW-1:0]   next_f, upc_inc, opc;
  logic            full, empty;
  logic            adv, push, pop, load_ir, set_ovf, set_unf, clr;

  assign next_f   = cw[AW-1:0];
  assign mode     = cw[AW+2:AW];
  assign csel     = cw[AW+4:AW+3];
  assign ctrl     = cw[CW-1:AW+5];
  assign upc_inc  = upc + AW'(1);
  assign opc      = instr[OPC_LSB+AW-1:OPC_LSB];
  assign full     = (sp == SPW'(STACK_DEPTH));
  assign empty    = (sp == '0);
  assign sp_dec   = sp - SPW'(1);
  assign push_idx = sp[SIW-1:0];
  assign pop_idx  = sp_dec[SIW-1:0];
  // Handshake and status outputs drop as soon as reset is asserted.
  assign halted   = (state == HALT) && !reset;

  always_comb begin
    state_nxt   = state;
    nxt         = upc;
    adv         = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    load_ir     = 1'b0;
    set_ovf     = 1'b0;
    set_unf     = 1'b0;
    clr         = 1'b0;
    instr_ready = 1'b0;
    ctrl_valid  = 1'b0;
    unique case (state)
      BOOT: begin
        nxt       = '0;
        adv       = 1'b1;
        state_nxt = RUN;
      end
      HALT: begin
        if (resume) begin
          nxt       = '0;
          adv       = 1'b1;
          clr       = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!ext_stall) begin
          ctrl_valid = 1'b1;
          case (mode)
            M_SEQ: begin
              nxt = upc_inc;
              adv = 1'b1;
            end
            M_JMP: begin
              nxt = next_f;
              adv = 1'b1;
            end
            M_DISP: begin
              if (instr_valid) begin
                instr_ready = 1'b1;
                load_ir     = 1'b1;
                nxt         = opc;
                adv         = 1'b1;
              end else begin
                // Waiting for an instruction: the word is not executing.
                ctrl_valid = 1'b0;
              end
            end
            M_BR: begin
              nxt = flags[csel] ? next_f : upc_inc;
              adv = 1'b1;
            end
            M_CALL: begin
              if (full) begin
                set_ovf   = 1'b1;
                state_nxt = HALT;
              end else begin
                push = 1'b1;
                nxt  = next_f;
                adv  = 1'b1;
              end
            end
            M_RET: begin
              if (empty) begin
                set_unf   = 1'b1;
                state_nxt = HALT;
              end else begin
                pop = 1'b1;
                nxt = stk[pop_idx];
                adv = 1'b1;
              end
            end
            M_WAIT: begin
              // Re-reads the same word while the flag is low so store writes are seen.
              nxt = flags[csel] ? upc_inc : upc;
              adv = 1'b1;
            end
            default: begin
              state_nxt = HALT;
            end
          endcase
        end
      end
      default: state_nxt = BOOT;
    endcase
    if (reset) begin
      instr_ready = 1'b0;
      ctrl_valid  = 1'b0;
    end
  end

  // Control store: never reset; the cw read below sees the pre-write word on a collision.
  always_ff @(posedge eclk) begin
    if (cs_we) cs[cs_waddr] <= cs_wdata;
  end

  always_ff @(posedge eclk) begin
    if (!reset && push) stk[push_idx] <= upc_inc;
  end

  always_ff @(posedge eclk) begin
    if (reset) begin
      state <= BOOT;
      upc   <= '0;
      cw    <= '0;
      ir    <= '0;
      sp    <= '0;
      err   <= '0;
    end else begin
      state <= state_nxt;
      if (adv) begin
        upc <= nxt;
        cw  <= cs[nxt];
      end
      if (load_ir) ir <= instr;
      if (clr) begin
        sp  <= '0;
        err <= '0;
      end else begin
        if (push)     sp <= sp + SPW'(1);
        else if (pop) sp <= sp_dec;
        if (set_ovf) err[0] <= 1'b1;
        if (set_unf) err[1] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Testbench for micro_sequencer: directed scenarios plus randomized traffic against a reference model.
// Latency: expectations are queued per cycle and compared on the following falling edge.
// Backpressure: none; the monitor drains the queue independently of the stimulus.
module tb_micro_sequencer;
  localparam int AW = 4;
  localparam int CW = 29;
  localparam int DW = 8;
  localparam int OPC_LSB = 2;
  localparam int SD = 4;
  localparam int NW = 1 << AW;
  localparam int S_BOOT = 0;
  localparam int S_RUN = 1;
  localparam int S_HALT = 2;

  logic eclk = 1'b0;
  always #5 eclk = ~eclk;

  logic             reset, cs_we;
  logic [AW-1:0]    cs_waddr;
  logic [CW-1:0]    cs_wdata;
  logic [DW-1:0]    instr;
  logic             instr_valid, instr_ready;
  logic [3:0]       flags;
  logic             ext_stall, resume;
  logic [CW-AW-6:0] ctrl;
  logic             ctrl_valid;
  logic [AW-1:0]    upc;
  logic [DW-1:0]    ir;
  logic             halted;
  logic [1:0]       err;

  micro_sequencer #(.AW(AW), .CW(CW), .DW(DW), .OPC_LSB(OPC_LSB), .STACK_DEPTH(SD)) dut (
    .eclk(eclk), .reset(reset), .cs_we(cs_we), .cs_waddr(cs_waddr), .cs_wdata(cs_wdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .flags(flags),
    .ext_stall(ext_stall), .resume(resume), .ctrl(ctrl), .ctrl_valid(ctrl_valid),
    .upc(upc), .ir(ir), .halted(halted), .err(err)
  );

  typedef struct {
    logic [CW-AW-6:0] ctrl;
    logic             cv;
    logic             rdy;
    logic             hlt;
    logic [AW-1:0]    upc;
    logic [DW-1:0]    ir;
    logic [1:0]       err;
  } exp_t;

  exp_t sbq[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: store contents, architectural state, call stack as a queue.
  logic [CW-1:0] mem [NW];
  int            m_st = S_BOOT;
  int            m_upc = 0;
  logic [CW-1:0] m_cw = '0;
  logic [DW-1:0] m_ir = '0;
  logic [1:0]    m_err = '0;
  int            m_stk[$];
  bit            known = 1'b0;

  function automatic logic [CW-1:0] mk(input int mode, input int csel, input int nx, input int c);
    return {c[CW-AW-6:0], csel[1:0], mode[2:0], nx[AW-1:0]};
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    logic [2:0] mode;
    logic running;
    mode    = m_cw[AW+2:AW];
    running = (m_st == S_RUN) && !ext_stall && !reset;
    e.ctrl  = m_cw[CW-1:AW+5];
    e.upc   = m_upc[AW-1:0];
    e.ir    = m_ir;
    e.err   = m_err;
    e.rdy   = running && (mode == 3'd2) && instr_valid;
    e.cv    = running && !((mode == 3'd2) && !instr_valid);
    e.hlt   = (m_st == S_HALT) && !reset;
    return e;
  endfunction

  task automatic model_update();
    int nx;
    bit go;
    logic [2:0] mode;
    logic [1:0] csel;
    int nextf;
    int inc;
    mode  = m_cw[AW+2:AW];
    csel  = m_cw[AW+4:AW+3];
    nextf = int'(m_cw[AW-1:0]);
    inc   = (m_upc + 1) % NW;
    if (reset) begin
      m_st = S_BOOT; m_upc = 0; m_cw = '0; m_ir = '0; m_err = '0;
      m_stk.delete();
      known = 1'b1;
    end else if (m_st == S_BOOT) begin
      m_st = S_RUN; m_upc = 0; m_cw = mem[0];
    end else if (m_st == S_HALT) begin
      if (resume) begin
        m_err = '0; m_stk.delete();
        m_st = S_RUN; m_upc = 0; m_cw = mem[0];
      end
    end else if (!ext_stall) begin
      go = 1'b1;
      nx = m_upc;
      case (mode)
        3'd0: nx = inc;
        3'd1: nx = nextf;
        3'd2: if (instr_valid) begin
                m_ir = instr;
                nx = int'(instr[OPC_LSB+AW-1:OPC_LSB]);
              end else go = 1'b0;
        3'd3: nx = flags[csel] ? nextf : inc;
        3'd4: if (m_stk.size() == SD) begin
                m_err[0] = 1'b1; m_st = S_HALT; go = 1'b0;
              end else begin
                m_stk.push_back(inc); nx = nextf;
              end
        3'd5: if (m_stk.size() == 0) begin
                m_err[1] = 1'b1; m_st = S_HALT; go = 1'b0;
              end else nx = m_stk.pop_back();
        3'd6: nx = flags[csel] ? inc : m_upc;
        default: begin m_st = S_HALT; go = 1'b0; end
      endcase
      if (go) begin
        m_upc = nx;
        m_cw  = mem[nx];
      end
    end
    if (cs_we) mem[cs_waddr] = cs_wdata;
  endtask

  task automatic step();
    if (known) sbq.push_back(expect_now());
    @(posedge eclk);
    model_update();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic ld(input int a, input logic [CW-1:0] w);
    cs_we = 1'b1; cs_waddr = a[AW-1:0]; cs_wdata = w;
    step();
    cs_we = 1'b0;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: dut=%0h expected=%0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge eclk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      check("upc", 32'(upc), 32'(e.upc));
      check("ctrl", 32'(ctrl), 32'(e.ctrl));
      check("ctrl_valid", 32'(ctrl_valid), 32'(e.cv));
      check("instr_ready", 32'(instr_ready), 32'(e.rdy));
      check("halted", 32'(halted), 32'(e.hlt));
      check("ir", 32'(ir), 32'(e.ir));
      check("err", 32'(err), 32'(e.err));
    end
  end

  initial begin
    logic [31:0] r;
    reset = 1'b1; cs_we = 1'b0; cs_waddr = '0; cs_wdata = '0; instr = '0;
    instr_valid = 1'b0; flags = '0; ext_stall = 1'b0; resume = 1'b0;

    // Boot and SEQ wrap-around.
    for (int k = 0; k < NW; k++) ld(k, mk(0, 0, 0, k + 1));
    reset = 1'b0;
    run(20);

    // Dispatch: three idle cycles, then accept 8'hB0 -> upc 12.
    reset = 1'b1;
    ld(0, mk(2, 0, 0, 'h22));
    reset = 1'b0;
    step();
    instr = 8'hB0;
    run(3);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    run(3);

    // Branch taken (flags[2]=1 -> 9) and not taken (-> 4).
    reset = 1'b1;
    ld(0, mk(1, 0, 3, 'h30));
    ld(3, mk(3, 2, 9, 'h33));
    ld(9, mk(1, 0, 3, 'h39));
    reset = 1'b0;
    run(2);
    flags = 4'b0100;
    step();
    flags = 4'b0000;
    run(5);

    // Nested calls four deep, returns to each upc+1, then HALT word.
    reset = 1'b1;
    ld(0, mk(4, 0, 2, 'h40)); ld(2, mk(4, 0, 4, 'h42));
    ld(4, mk(4, 0, 6, 'h44)); ld(6, mk(4, 0, 8, 'h46));
    ld(8, mk(5, 0, 0, 'h48)); ld(7, mk(5, 0, 0, 'h47));
    ld(5, mk(5, 0, 0, 'h45)); ld(3, mk(5, 0, 0, 'h43));
    ld(1, mk(7, 0, 0, 'h41));
    reset = 1'b0;
    run(12);
    // Fifth nested call overflows, then resume.
    reset = 1'b1;
    ld(8, mk(4, 0, 10, 'h58));
    reset = 1'b0;
    run(10);
    resume = 1'b1;
    step();
    resume = 1'b0;
    run(3);

    // Underflow; stall ignored while halted.
    reset = 1'b1;
    ld(0, mk(5, 0, 0, 'h50));
    reset = 1'b0;
    run(4);
    ext_stall = 1'b1; resume = 1'b1;
    step();
    ext_stall = 1'b0; resume = 1'b0;
    run(2);
    // Stall during dispatch and during sequencing.
    reset = 1'b1;
    ld(0, mk(2, 0, 0, 'h60)); ld(5, mk(0, 0, 0, 'h65)); ld(6, mk(0, 0, 0, 'h66));
    reset = 1'b0;
    step();
    instr = 8'h14; instr_valid = 1'b1; ext_stall = 1'b1;
    step();
    ext_stall = 1'b0;
    step();
    instr_valid = 1'b0;
    step();
    ext_stall = 1'b1;
    run(2);
    ext_stall = 1'b0;
    run(2);

    // Reset mid-call clears the stack; store write collides with the boot read of cs[0].
    reset = 1'b1;
    ld(0, mk(0, 0, 0, 'h70)); ld(1, mk(4, 0, 3, 'h71)); ld(3, mk(4, 0, 5, 'h73));
    ld(5, mk(6, 0, 0, 'h75)); ld(6, mk(5, 0, 0, 'h76)); ld(4, mk(5, 0, 0, 'h74));
    ld(2, mk(5, 0, 0, 'h72));
    reset = 1'b0; flags = 4'b0000;
    run(3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    ld(0, mk(0, 0, 0, 'hABCDE));
    run(4);
    flags = 4'b0001;
    run(6);
    flags = 4'b0000; resume = 1'b1;
    step();
    resume = 1'b0;
    run(3);

    // Randomized traffic over a random store.
    reset = 1'b1;
    for (int k = 0; k < NW; k++) begin
      r = $urandom;
      ld(k, r[CW-1:0]);
    end
    reset = 1'b0;
    repeat (3000) begin
      r = $urandom; instr = r[DW-1:0];
      r = $urandom; flags = r[3:0];
      instr_valid = ($urandom_range(0, 9) < 7);
      ext_stall   = ($urandom_range(0, 9) == 0);
      resume      = ($urandom_range(0, 2) == 0);
      cs_we       = ($urandom_range(0, 19) == 0);
      r = $urandom; cs_waddr = r[AW-1:0];
      r = $urandom; cs_wdata = r[CW-1:0];
      reset       = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0; cs_we = 1'b0; ext_stall = 1'b0; resume = 1'b0;
    step();
    @(negedge eclk);
    #1;
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: dut=%0d pending expected=0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
